conv_stream_engine: RTL and testbench

- Parametrised successor to the fixed 8x8 linear-convolution block.
- Computes y[n] = sum over k of x[k]*h[n-k] for n = 0..NX+NH-2, with configurable sequence lengths, data width and signed/unsigned mode.
- Uses one time-shared MAC with a start/busy/done handshake and a valid/ready output stream; outputs are full-width with no truncation.
- Sits between operand registers and downstream result storage/accumulation logic.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/conv_mac.sv | 40 ++++
 rtl/conv_stream_engine.sv | 124 ++++++++++++
 tb/tb_conv_stream_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and index/width helpers for the streaming convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index ports need at least one bit even when only a single value exists.
  function automatic int unsigned idx_width(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned nx,
                                            input int unsigned nh);
    return 2 * w + clog2((nx < nh) ? nx : nh);
  endfunction

  function automatic int unsigned kmin(input int unsigned n, input int unsigned nh);
    return (n + 1 >= nh) ? n + 1 - nh : 0;
  endfunction

  function automatic int unsigned kmax(input int unsigned n, input int unsigned nx);
    return (n < nx - 1) ? n : nx - 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate with synchronous clear and enable.
module conv_mac
  import conv_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned ACC_W  = 19,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] prod_ext;

  // Product is extended to the accumulator width before summing.
  if (SIGNED != 0) begin : g_signed
    logic signed [2*W-1:0] prod;
    always_comb begin
      prod     = (2*W)'($signed(a)) * (2*W)'($signed(b));
      prod_ext = ACC_W'(prod);
    end
  end else begin : g_unsigned
    logic [2*W-1:0] prod;
    always_comb begin
      prod     = (2*W)'(a) * (2*W)'(b);
      prod_ext = ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn || clr) acc <= '0;
    else if (en)     acc <= acc + prod_ext;
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Time-shared linear convolution: one MAC per term, results streamed out with valid/ready.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter  int unsigned W      = 8,
  parameter  int unsigned NX     = 8,
  parameter  int unsigned NH     = 8,
  parameter  int unsigned SIGNED = 0,
  localparam int unsigned L      = NX + NH - 1,
  localparam int unsigned ACC_W  = acc_width(W, NX, NH),
  localparam int unsigned IDX_W  = idx_width(L)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [NX*W-1:0]    x_in,
  input  logic [NH*W-1:0]    h_in,
  output logic               busy,
  output logic               done,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [ACC_W-1:0]   y_data,
  output logic [IDX_W-1:0]   y_idx,
  output logic               y_last
);

  localparam int unsigned KW = idx_width(NX);
  localparam int unsigned HW = idx_width(NH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     x_q [NX];
  logic [W-1:0]     h_q [NH];
  logic [HW-1:0]    hsel;
  logic [W-1:0]     op_a, op_b;
  logic             last_term, snap, mac_clr, mac_en;

  assign hsel      = HW'(32'(n_q) - 32'(k_q));
  assign last_term = (32'(k_q) == kmax(32'(n_q), NX));
  assign op_a      = x_q[k_q];
  assign op_b      = h_q[hsel];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    snap    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap    = 1'b1;
          mac_clr = 1'b1;
          n_d     = '0;
          k_d     = KW'(kmin(0, NH));
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_term) state_d = OUT;
        else           k_d     = k_q + KW'(1);
      end
      OUT: begin
        if (y_ready) begin
          if (n_q == IDX_W'(L - 1)) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + IDX_W'(1);
            k_d     = KW'(kmin(32'(n_q) + 32'd1, NH));
            mac_clr = 1'b1;
            state_d = MAC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_idx   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      busy    <= (state_d == MAC) || (state_d == OUT);
      done    <= (state_d == DONE);
      y_valid <= (state_d == OUT);
      y_last  <= (state_d == OUT) && (n_d == IDX_W'(L - 1));
      y_idx   <= n_d;
    end
  end

  // Operand snapshot: the running job is isolated from later input changes.
  always_ff @(posedge clk) begin
    if (snap) begin
      for (int i = 0; i < int'(NX); i++) x_q[i] <= x_in[i*W +: W];
      for (int i = 0; i < int'(NH); i++) h_q[i] <= h_in[i*W +: W];
    end
  end

  conv_mac #(.W(W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
    .clk  (clk),
    .rstn (rstn),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (op_a),
    .b    (op_b),
    .acc  (y_data)
  );

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: three configurations run side by side against a direct-sum reference.
module tb_conv_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, y_ready, start_a, start_b, start_c;
  logic [63:0] xa, ha, xc, hc;
  logic [23:0] xb;
  logic [39:0] hb;
  logic busy_a, done_a, yv_a, yl_a, busy_b, done_b, yv_b, yl_b, busy_c, done_c, yv_c, yl_c;
  logic [18:0] yd_a, yd_c;
  logic [17:0] yd_b;
  logic [3:0]  yi_a, yi_c;
  logic [2:0]  yi_b;

  conv_stream_engine u_a (
    .clk(clk), .rstn(rstn), .start(start_a), .x_in(xa), .h_in(ha), .busy(busy_a), .done(done_a),
    .y_valid(yv_a), .y_ready(y_ready), .y_data(yd_a), .y_idx(yi_a), .y_last(yl_a));

  conv_stream_engine #(.W(8), .NX(3), .NH(5), .SIGNED(1)) u_b (
    .clk(clk), .rstn(rstn), .start(start_b), .x_in(xb), .h_in(hb), .busy(busy_b), .done(done_b),
    .y_valid(yv_b), .y_ready(y_ready), .y_data(yd_b), .y_idx(yi_b), .y_last(yl_b));

  conv_stream_engine #(.SIGNED(1)) u_c (
    .clk(clk), .rstn(rstn), .start(start_c), .x_in(xc), .h_in(hc), .busy(busy_c), .done(done_c),
    .y_valid(yv_c), .y_ready(y_ready), .y_data(yd_c), .y_idx(yi_c), .y_last(yl_c));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  int     qa_idx[$], qb_idx[$], qc_idx[$];
  longint qa_dat[$], qb_dat[$], qc_dat[$];
  bit     qa_last[$], qb_last[$], qc_last[$];
  int     done_cnt_a, done_cnt_b, done_cnt_c;
  int     done_at_a, done_at_b, done_at_c, first_va;
  bit     busy_done_a;

  typedef struct packed {
    logic [63:0] xa, ha;
    logic [23:0] xb;
    logic [39:0] hb;
    logic [63:0] xc, hc;
    longint      ea0, ea7, ea14, eb3, ec7;
  } vec_t;
  vec_t tbl [3];

  longint ramp_exp [15] = '{1, 3, 6, 10, 15, 21, 28, 36, 35, 33, 30, 26, 21, 15, 8};
  longint b_exp    [7]  = '{1, 2, 2, -2, -3, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors: record each accepted result and every done pulse.
  always @(negedge clk) begin
    if (yv_a && y_ready) begin
      qa_idx.push_back(int'(yi_a)); qa_dat.push_back(longint'(yd_a)); qa_last.push_back(yl_a);
      if (first_va < 0) first_va = cyc + 1 - t0;
    end
    if (yv_b && y_ready) begin
      qb_idx.push_back(int'(yi_b)); qb_dat.push_back(longint'($signed(yd_b))); qb_last.push_back(yl_b);
    end
    if (yv_c && y_ready) begin
      qc_idx.push_back(int'(yi_c)); qc_dat.push_back(longint'($signed(yd_c))); qc_last.push_back(yl_c);
    end
    if (done_a) begin
      done_cnt_a++;
      if (done_at_a < 0) begin done_at_a = cyc + 1 - t0; busy_done_a = busy_a; end
    end
    if (done_b) begin done_cnt_b++; if (done_at_b < 0) done_at_b = cyc + 1 - t0; end
    if (done_c) begin done_cnt_c++; if (done_at_c < 0) done_at_c = cyc + 1 - t0; end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: y[n] is the sum of x[k]*h[j] over all pairs with k+j == n.
  function automatic longint ref_y(input int n, input longint xv[64], input longint hv[64],
                                   input int nx, input int nh);
    longint s = 0;
    for (int k = 0; k < nx; k++)
      for (int j = 0; j < nh; j++)
        if (k + j == n) s += xv[k] * hv[j];
    return s;
  endfunction

  task automatic cmp_seq(input string tag, input longint exp[$], input int iq[$],
                         input longint dq[$], input bit lq[$]);
    chk({tag, "_count"}, longint'(iq.size()), longint'(exp.size()));
    for (int n = 0; n < exp.size() && n < iq.size(); n++) begin
      chk({tag, "_idx"},  longint'(iq[n]), longint'(n));
      chk({tag, "_data"}, dq[n], exp[n]);
      chk({tag, "_last"}, longint'(lq[n]), longint'(n == exp.size() - 1));
    end
  endtask

  // mode 0: ready held high; 1: random ready; 2: 5-cycle stall at index 3;
  // 3: restart pulse and operand change mid-job, plus start during DONE.
  task automatic run_job(input logic [63:0] xa_i, ha_i, input logic [23:0] xb_i,
                         input logic [39:0] hb_i, input logic [63:0] xc_i, hc_i, input int mode);
    longint xv[64], hv[64];
    longint ea[$], eb[$], ec[$];
    int     cycles, stall_left, stalled;
    longint held_d;
    for (int k = 0; k < 64; k++) begin xv[k] = 0; hv[k] = 0; end
    for (int k = 0; k < 8; k++) begin xv[k] = longint'(xa_i[k*8 +: 8]); hv[k] = longint'(ha_i[k*8 +: 8]); end
    for (int n = 0; n < 15; n++) ea.push_back(ref_y(n, xv, hv, 8, 8));
    for (int k = 0; k < 8; k++) begin
      xv[k] = longint'($signed(xc_i[k*8 +: 8])); hv[k] = longint'($signed(hc_i[k*8 +: 8]));
    end
    for (int n = 0; n < 15; n++) ec.push_back(ref_y(n, xv, hv, 8, 8));
    for (int k = 0; k < 64; k++) begin xv[k] = 0; hv[k] = 0; end
    for (int k = 0; k < 3; k++) xv[k] = longint'($signed(xb_i[k*8 +: 8]));
    for (int k = 0; k < 5; k++) hv[k] = longint'($signed(hb_i[k*8 +: 8]));
    for (int n = 0; n < 7; n++) eb.push_back(ref_y(n, xv, hv, 3, 5));

    xa = xa_i; ha = ha_i; xb = xb_i; hb = hb_i; xc = xc_i; hc = hc_i;
    qa_idx.delete(); qa_dat.delete(); qa_last.delete();
    qb_idx.delete(); qb_dat.delete(); qb_last.delete();
    qc_idx.delete(); qc_dat.delete(); qc_last.delete();
    done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
    done_at_a = -1; done_at_b = -1; done_at_c = -1; first_va = -1; busy_done_a = 1'b1;
    stall_left = 0; stalled = 0; held_d = 0;

    @(posedge clk); #1;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; y_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    chk("busy_after_start", longint'(busy_a), 1);
    for (cycles = 0; cycles < 3000 && (done_at_a < 0 || done_at_b < 0 || done_at_c < 0); cycles++) begin
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      case (mode)
        1: y_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0) begin
            chk("stall_valid", longint'(yv_a), 1);
            chk("stall_idx",   longint'(yi_a), 3);
            chk("stall_data",  longint'(yd_a), held_d);
            stall_left--;
            y_ready = (stall_left == 0);
          end else if (stalled == 0 && yv_a && yi_a == 4'd3) begin
            stalled = 1; held_d = longint'(yd_a); y_ready = 1'b0; stall_left = 5;
          end
        end
        3: begin
          y_ready = 1'b1;
          if (cycles == 5) begin
            start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
            xa = ~xa_i; ha = {$urandom, $urandom}; xb = 24'($urandom); hb = {8'($urandom), $urandom};
            xc = {$urandom, $urandom}; hc = {$urandom, $urandom};
          end
          if (done_a) start_a = 1'b1;
        end
        default: y_ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    chk("job_completed", longint'(done_at_a >= 0 && done_at_b >= 0 && done_at_c >= 0), 1);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_idle_after", longint'(busy_a), 0);
    chk("b_idle_after", longint'(busy_b), 0);
    chk("c_idle_after", longint'(busy_c), 0);
    chk("a_busy_at_done", longint'(busy_done_a), 0);
    chk("a_done_pulses", longint'(done_cnt_a), 1);
    chk("b_done_pulses", longint'(done_cnt_b), 1);
    chk("c_done_pulses", longint'(done_cnt_c), 1);
    cmp_seq("a", ea, qa_idx, qa_dat, qa_last);
    cmp_seq("b", eb, qb_idx, qb_dat, qb_last);
    cmp_seq("c", ec, qc_idx, qc_dat, qc_last);
    if (mode == 0) begin
      chk("a_first_valid_lat", longint'(first_va), 2);
      chk("a_done_lat", longint'(done_at_a), 80);
      chk("b_done_lat", longint'(done_at_b), 23);
      chk("c_done_lat", longint'(done_at_c), 80);
    end
  endtask

  task automatic reset_mid_job();
    bit found;
    found = 1'b0;
    xa = {$urandom, $urandom}; ha = {$urandom, $urandom};
    y_ready = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (yv_a && yi_a == 4'd4) begin found = 1'b1; break; end
    end
    chk("rst_reached_idx4", longint'(found), 1);
    @(posedge clk); #1;
    chk("rst_in_mac_busy", longint'(busy_a), 1);
    chk("rst_in_mac_valid", longint'(yv_a), 0);
    rstn = 1'b1;
    done_cnt_a = 0;
    @(posedge clk); #1;
    chk("rst_busy", longint'(busy_a), 0);
    chk("rst_valid", longint'(yv_a), 0);
    chk("rst_done", longint'(done_a), 0);
    chk("rst_data", longint'(yd_a), 0);
    chk("rst_idx", longint'(yi_a), 0);
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_done", longint'(done_cnt_a), 0);
    chk("rst_stays_idle", longint'(busy_a), 0);
  endtask

  initial begin
    rstn = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; y_ready = 1'b1;
    xa = '0; ha = '0; xb = '0; hb = '0; xc = '0; hc = '0;
    done_at_a = -1; done_at_b = -1; done_at_c = -1; first_va = -1;

    tbl[0] = '{xa: 64'h0807060504030201, ha: 64'h0101010101010101, xb: 24'h030201,
               hb: 40'h0000FF0001, xc: 64'h8080808080808080, hc: 64'h8080808080808080,
               ea0: 1, ea7: 36, ea14: 8, eb3: -2, ec7: 131072};
    tbl[1] = '{xa: 64'hFFFFFFFFFFFFFFFF, ha: 64'hFFFFFFFFFFFFFFFF, xb: 24'h808080,
               hb: 40'h7F7F7F7F7F, xc: 64'h7F7F7F7F7F7F7F7F, hc: 64'h7F7F7F7F7F7F7F7F,
               ea0: 65025, ea7: 520200, ea14: 65025, eb3: -48768, ec7: 129032};
    tbl[2] = '{xa: '0, ha: '0, xb: '0, hb: '0, xc: '0, hc: '0,
               ea0: 0, ea7: 0, ea14: 0, eb3: 0, ec7: 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(busy_a), 0);
    chk("reset_done", longint'(done_a), 0);
    chk("reset_valid", longint'(yv_a), 0);
    chk("reset_last", longint'(yl_a), 0);
    chk("reset_data", longint'(yd_a), 0);
    chk("reset_idx", longint'(yi_a), 0);
    chk("reset_b_valid", longint'(yv_b), 0);
    chk("reset_c_busy", longint'(busy_c), 0);
    rstn = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_job(tbl[i].xa, tbl[i].ha, tbl[i].xb, tbl[i].hb, tbl[i].xc, tbl[i].hc, (i == 0) ? 0 : (i == 1) ? 2 : 3);
      chk("tbl_a_y0", qa_dat[0], tbl[i].ea0);
      chk("tbl_a_y7", qa_dat[7], tbl[i].ea7);
      chk("tbl_a_y14", qa_dat[14], tbl[i].ea14);
      chk("tbl_b_y3", qb_dat[3], tbl[i].eb3);
      chk("tbl_c_y7", qc_dat[7], tbl[i].ec7);
      if (i == 0) begin
        for (int n = 0; n < 15; n++) chk("ramp_y", qa_dat[n], ramp_exp[n]);
        for (int n = 0; n < 7; n++) chk("b_small_y", qb_dat[n], b_exp[n]);
      end
    end

    for (int j = 0; j < 4; j++)
      run_job({$urandom, $urandom}, {$urandom, $urandom}, 24'($urandom), {8'($urandom), $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 1);

    reset_mid_job();
    run_job({$urandom, $urandom}, {$urandom, $urandom}, 24'($urandom), {8'($urandom), $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
